// File: rtl/jogador_automatico.sv
// jogador_automatico
// Automatic player for the Genius memory game. It listens to the game's LED
// output while the sequence is shown and stores each colour. When the game
// hands the turn over, it replays the stored colours as timed button presses.
//
// Ports:
//   clock        - single clock, rising edge
//   reset        - synchronous, active-low reset
//   habilita     - enables automatic play; low forces IDLE and clears flags
//   leds[6:0]    - game LED output; only [3:0] carry colours
//   vez_jogador  - high while the game accepts button input
//   botoes[6:0]  - registered button drive to the game ([6:4] always 0)
//   ocupado      - high while replaying (PRESSIONA or SOLTA)
//   db_tamanho   - number of entries captured in the current round
//   db_invalido  - sticky: an invalid LED pattern was seen
//   db_overflow  - sticky: a valid colour arrived with the store full
//   db_estado    - state code (IDLE=0 ESCUTA=1 PRESSIONA=2 SOLTA=3 FIM=4)
module jogador_automatico #(
  parameter int MAX_SEQ      = 16,
  parameter int PRESS_CYCLES = 4,
  parameter int GAP_CYCLES   = 4
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      habilita,
  input  logic [6:0]                leds,
  input  logic                      vez_jogador,
  output logic [6:0]                botoes,
  output logic                      ocupado,
  output logic [$clog2(MAX_SEQ):0]  db_tamanho,
  output logic                      db_invalido,
  output logic                      db_overflow,
  output logic [3:0]                db_estado
);

  localparam int IW   = $clog2(MAX_SEQ) + 1;
  localparam int AW   = (MAX_SEQ > 1) ? $clog2(MAX_SEQ) : 1;
  localparam int CMAX = (PRESS_CYCLES > GAP_CYCLES) ? PRESS_CYCLES : GAP_CYCLES;
  localparam int CW   = $clog2(CMAX) + 1;

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] ESCUTA    = 3'd1;
  localparam logic [2:0] PRESSIONA = 3'd2;
  localparam logic [2:0] SOLTA     = 3'd3;
  localparam logic [2:0] FIM       = 3'd4;

  logic [2:0]    estado;
  logic [IW-1:0] idx;
  logic [IW-1:0] ptr;
  logic [IW-1:0] len;
  logic [CW-1:0] cnt;
  logic [6:0]    leds_ant;
  logic [3:0]    mem [0:(1<<AW)-1];

  logic          evento;
  logic          cor_valida;
  logic          cheio;
  logic          grava;
  logic [IW-1:0] idx_novo;

  // One event per LED pulse: only the transition from dark to lit counts.
  // A colour is valid when exactly one of the four colour bits is set.
  always_comb begin
    evento     = (leds_ant == 7'd0) && (leds != 7'd0);
    cor_valida = (leds[6:4] == 3'd0) && (leds[3:0] != 4'd0) &&
                 ((leds[3:0] & (leds[3:0] - 4'd1)) == 4'd0);
    cheio      = (idx == IW'(MAX_SEQ));
    grava      = reset && habilita && (estado == ESCUTA) &&
                 evento && cor_valida && !cheio;
    // The capture of this cycle is folded in before the turn-start decision,
    // so a colour arriving together with the turn is still replayed.
    idx_novo   = grava ? (idx + IW'(1)) : idx;
  end

  // Sequence store; contents are don't-care after reset, so it has none.
  always_ff @(posedge clock) begin
    if (grava) begin
      mem[idx[AW-1:0]] <= leds[3:0];
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      estado      <= IDLE;
      idx         <= '0;
      ptr         <= '0;
      len         <= '0;
      cnt         <= '0;
      leds_ant    <= 7'd0;
      botoes      <= 7'd0;
      db_invalido <= 1'b0;
      db_overflow <= 1'b0;
    end else begin
      // Tracked in every state so a LED already lit on entry to ESCUTA
      // is not mistaken for a new colour.
      leds_ant <= leds;
      if (!habilita) begin
        estado      <= IDLE;
        idx         <= '0;
        ptr         <= '0;
        cnt         <= '0;
        botoes      <= 7'd0;
        db_invalido <= 1'b0;
        db_overflow <= 1'b0;
      end else begin
        case (estado)
          IDLE: begin
            idx    <= '0;
            botoes <= 7'd0;
            estado <= ESCUTA;
          end
          ESCUTA: begin
            botoes <= 7'd0;
            idx    <= idx_novo;
            if (evento && !cor_valida) db_invalido <= 1'b1;
            if (evento && cor_valida && cheio) db_overflow <= 1'b1;
            if (vez_jogador && (idx_novo != '0)) begin
              len    <= idx_novo;
              ptr    <= '0;
              cnt    <= '0;
              estado <= PRESSIONA;
            end
          end
          PRESSIONA: begin
            // Losing the turn mid-replay means the game timed out or erred.
            if (!vez_jogador) begin
              estado <= ESCUTA;
              idx    <= '0;
              cnt    <= '0;
              botoes <= 7'd0;
            end else begin
              botoes <= {3'b000, mem[ptr[AW-1:0]]};
              if (cnt == CW'(PRESS_CYCLES - 1)) begin
                cnt    <= '0;
                estado <= SOLTA;
              end else begin
                cnt <= cnt + CW'(1);
              end
            end
          end
          SOLTA: begin
            if (!vez_jogador) begin
              estado <= ESCUTA;
              idx    <= '0;
              cnt    <= '0;
              botoes <= 7'd0;
            end else begin
              botoes <= 7'd0;
              if (cnt == CW'(GAP_CYCLES - 1)) begin
                cnt    <= '0;
                ptr    <= ptr + IW'(1);
                estado <= ((ptr + IW'(1)) == len) ? FIM : PRESSIONA;
              end else begin
                cnt <= cnt + CW'(1);
              end
            end
          end
          FIM: begin
            botoes <= 7'd0;
            // The game re-displays the whole sequence next round.
            if (!vez_jogador) begin
              idx    <= '0;
              estado <= ESCUTA;
            end
          end
          default: begin
            botoes <= 7'd0;
            estado <= IDLE;
          end
        endcase
      end
    end
  end

  assign ocupado    = (estado == PRESSIONA) || (estado == SOLTA);
  assign db_tamanho = idx;
  assign db_estado  = {1'b0, estado};

endmodule

// File: doc/jogador_automatico.md
# jogador_automatico

Automatic player for the Genius memory game. It sits on the opposite side of the game's LED/button interface: it watches the LED output while the game displays the sequence, stores each displayed colour, and replays the stored sequence as timed button presses when the game hands the turn to the player. It is used for board demos and closed-loop regression of the game top. Its `botoes` output drives the game's button input directly.

## Interface
Parameters:
- `MAX_SEQ`, default 16: capacity of the sequence store, in entries.
- `PRESS_CYCLES`, default 4: number of cycles each button is held (minimum 1).
- `GAP_CYCLES`, default 4: number of released cycles after each press (minimum 1).

Ports:
- `clock`, input, 1 bit: single clock; all state changes on its rising edge.
- `reset`, input, 1 bit: synchronous, active-low reset.
- `habilita`, input, 1 bit: enables automatic play. Low forces IDLE.
- `leds`, input, 7 bits: game LED output. Only `[3:0]` are valid colours.
- `vez_jogador`, input, 1 bit: high while the game accepts button input.
- `botoes`, output, 7 bits: registered button drive to the game. `[6:4]` are always 0.
- `ocupado`, output, 1 bit: high in PRESSIONA or SOLTA.
- `db_tamanho`, output, clog2(MAX_SEQ)+1 bits: number of entries captured in the current round.
- `db_invalido`, output, 1 bit: sticky flag, set when an invalid LED pattern is seen.
- `db_overflow`, output, 1 bit: sticky flag, set when a capture is attempted with the store full.
- `db_estado`, output, 4 bits: state code. IDLE=0, ESCUTA=1, PRESSIONA=2, SOLTA=3, FIM=4.

## Operation
- **Edge detect:** register `leds_ant`. A capture event is `leds_ant==0 && leds!=0`. Holding `leds` nonzero produces one event only.
- **Valid capture:** exactly one bit set in `leds[3:0]` and `leds[6:4]==0`. Store `mem[idx]=leds[3:0]` and increment `idx`.
- **Invalid capture:** no store and no increment; set `db_invalido`.
- **Full store:** with `idx==MAX_SEQ`, a valid event is dropped and sets `db_overflow`. `idx` saturates at `MAX_SEQ`.
- **IDLE:** `botoes=0`, `idx=0`. Moves to ESCUTA when `habilita=1`.
- **ESCUTA:** capture is active.
  - When `vez_jogador=1` and `idx>0`: latch `len=idx`, set `ptr=0`, go to PRESSIONA.
  - When `vez_jogador=1` and `idx==0`: stay in ESCUTA.
  - A capture event and `vez_jogador` rising in the same cycle: the capture is stored first, and the new `idx` is used as `len`.
- **PRESSIONA:** `botoes={3'b0, mem[ptr]}` for exactly PRESS_CYCLES cycles, then go to SOLTA.
- **SOLTA:** `botoes=0` for GAP_CYCLES cycles, then increment `ptr`.
  - If `ptr+1==len`, go to FIM.
  - Otherwise go to PRESSIONA.
- **FIM:** `botoes=0`. When `vez_jogador=0`, clear `idx` and go to ESCUTA. The game re-displays the whole sequence each round, so capture restarts from entry 0.
- **Abort:** `vez_jogador` falling during PRESSIONA or SOLTA (game timeout or error) goes to ESCUTA with `idx=0`.
- **Disable:** `habilita=0` in any state goes to IDLE next cycle and clears both sticky flags.
- **Priority per cycle:** `reset` > `habilita=0` > abort > normal transition.
- LED activity outside ESCUTA is ignored. `leds_ant` is still updated every cycle, so a LED already lit on entry to ESCUTA is not captured.

## Timing
- **Reset (`reset=0` at a clock edge):** state=IDLE, `botoes=0`, `ocupado=0`, `idx=0`, `ptr=0`, `leds_ant=0`, `db_tamanho=0`, `db_invalido=0`, `db_overflow=0`. Memory contents are don't-care.
- **Capture latency:** a LED rising edge at edge N makes `db_tamanho` increment at edge N+1.
- **Turn start:** with `vez_jogador` sampled high at edge N in ESCUTA:
  - state=PRESSIONA after edge N;
  - `botoes` shows `mem[0]` from edge N+1, for PRESS_CYCLES cycles.
- **Per-entry period:** PRESS_CYCLES+GAP_CYCLES cycles. A full replay takes `len*(PRESS_CYCLES+GAP_CYCLES)` cycles.
- **Output release:** `botoes` is 0 no later than one cycle after an abort, disable or reset is sampled.
- **Glitch-free button:** between consecutive presses `botoes` is 0 for at least GAP_CYCLES cycles, even when two consecutive entries are the same colour.

## Test plan
1. **Single capture:** reset, `habilita=1`, `leds` pulses 4'b0100 for 3 cycles, then `vez_jogador=1` → `db_tamanho=1`; `botoes=7'b0000100` for 4 cycles, then 0; state reaches FIM.
2. **Multi-entry round:** LED sequence 0001, 1000, 1000, 0010, with 0 gaps between → `db_tamanho=4`; replay presses 0001, 1000, 1000, 0010, each held 4 cycles with a 4-cycle 0 gap; after `vez_jogador` drops, next display round recaptures from index 0.
3. **Invalid and overflow:** `leds=7'b0000011` then `7'b0010000` → no capture, `db_invalido=1`; then 17 valid pulses with MAX_SEQ=16 → `db_tamanho=16`, `db_overflow=1`.
4. **Abort:** `vez_jogador` falls during the 2nd press → `botoes=0` next cycle, state=ESCUTA, `db_tamanho=0`.
5. **Same-cycle event:** LED rising edge in the same cycle `vez_jogador` rises, with `idx=2` → `len=3`; three presses are replayed.
6. **Reset/disable mid-play:** `reset=0` during PRESSIONA → all outputs at reset values next edge; `habilita=0` during SOLTA → IDLE and sticky flags cleared.
